digital_tx_stream: RTL and testbench
====================================

Name: digital_tx_stream

Overview:
Parametrised successor to the single-shot digital TX block. It buffers up to DEPTH words of DATA_WIDTH bits written by the host, then serialises them LSB-symbol-first as SYM_WIDTH-bit symbols on a ready/valid stream toward the modulator. It adds backpressure, a frame-last marker, overflow and error flags, and a continuous repeat mode. It sits between the AXI-lite/PS register front end and the DAC/modulator datapath.

Parameters:
DATA_WIDTH, 32, host word width; must be an integer multiple of SYM_WIDTH.
SYM_WIDTH, 8, output symbol width.
DEPTH, 16, word buffer depth; must be a power of 2, at least 2.
NUM_WIDTH, 32, width of i_data_num.
PRE_LEN, 4, preamble symbol count (only used with DIGITAL_TX_PREAMBLE_EN).
PRE_SYM, 8'h55, preamble symbol value, SYM_WIDTH bits.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  synchronous reset, active-low.
i_valid  in  1  one-cycle write strobe for i_data.
i_data  in  DATA_WIDTH  word to buffer; symbol 0 is in the LSBs.
i_clear  in  1  empties the buffer (write pointer reset to 0).
i_data_num  in  NUM_WIDTH  number of words to send; sampled on i_tx_start.
i_tx_start  in  1  one-cycle start pulse.
i_repeat  in  1  when 1 at the frame end, restart the frame from word 0.
i_tx_stop  in  1  stops repeat at the next frame end.
o_sym_data  out  SYM_WIDTH  output symbol.
o_sym_valid  out  1  output symbol valid.
i_sym_ready  in  1  downstream accept.
o_sym_last  out  1  marks the final symbol of a frame.
o_busy  out  1  high whenever state is not IDLE.
o_words  out  log2(DEPTH)+1  number of words currently stored.
o_overflow  out  1  sticky; cleared by i_clear or reset.
o_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (rst_n=0 at a clock edge, synchronous): all outputs 0, state IDLE, write pointer 0, stored words 0. Reset mid-frame aborts immediately and emits no further symbols.
- SPW = DATA_WIDTH/SYM_WIDTH. The symbol counter is log2(SPW) bits; SPW=1 is legal.
- Write path: in IDLE, i_valid writes buf[wr_ptr] and increments wr_ptr.
  - If wr_ptr==DEPTH, the write is dropped and o_overflow is set.
  - If o_busy=1, i_valid is ignored and does not set overflow.
  - i_clear has priority over i_valid in the same cycle. i_clear while busy is ignored.
- Start: in IDLE, on i_tx_start, latch N = min(i_data_num, o_words).
  - If N==0: stay in IDLE and pulse o_err for one cycle.
  - Otherwise go to SEND, with word index 0 and symbol index 0.
  - i_tx_start while busy is ignored, with no error pulse.
  - i_tx_start together with i_valid in the same cycle: the write is applied first, and N uses the updated count.
- States:
  - IDLE.
  - PRE (only when the macro is defined).
  - SEND. o_sym_valid=1; o_sym_data = buf[word][sym*SYM_WIDTH +: SYM_WIDTH].
- First symbol latency: o_sym_valid rises on the cycle after i_tx_start. Outputs are registered.
- Handshake (AXI-stream rules):
  - The symbol transfers on a cycle where o_sym_valid and i_sym_ready are both 1.
  - While valid=1 and ready=0, data and last are held stable.
  - Valid never drops mid-frame without a transfer.
  - With i_sym_ready held at 1, throughput is one symbol per cycle.
- Index advance on each transfer: sym increments; it wraps at SPW-1 and word then increments.
- o_sym_last=1 exactly when word==N-1 and sym==SPW-1.
- On transfer of the last symbol:
  - If i_repeat=1 and no stop is pending: word and sym return to 0 and the next symbol is presented on the next cycle. There is no gap, and the preamble is not resent.
  - Otherwise: go to IDLE; o_sym_valid=0 and o_busy=0 on the next cycle.
- Stop handling: i_tx_stop at any time during SEND sets stop_pending, which is cleared on entry to IDLE. i_tx_stop in IDLE has no effect.
- The buffer contents persist after a frame, so the host can restart without rewriting.

Optional Feature:
DIGITAL_TX_PREAMBLE_EN
- Defined: the start goes IDLE->PRE. PRE emits PRE_LEN symbols of PRE_SYM under the same handshake, with o_sym_last=0, then moves to SEND. The first preamble symbol appears on the cycle after start. The preamble is not repeated in repeat mode.
- Undefined: the PRE state, its counter, and the PRE_LEN/PRE_SYM logic are absent; IDLE goes directly to SEND.

Decomposition:
- Package digital_tx_pkg holds:
  - the state enum (IDLE, PRE, SEND);
  - the localparam functions SPW and clog2 helpers;
  - the default PRE_SYM.
- One sub-module, digital_tx_buf: a DEPTH x DATA_WIDTH register/BRAM with a write pointer, word count, overflow flag and a combinational read port.
- The FSM, symbol mux and handshake stay in digital_tx_stream.

Test Plan:
1. Basic frame: write 0x04030201 and 0x08070605, i_data_num=2, start, ready=1 -> symbols 01..08 on 8 consecutive cycles starting 1 cycle after start; last=1 only on 08; o_busy falls the cycle after.
2. Backpressure: same frame, ready toggling 1,0,0,1,... -> sequence still 01..08 with no duplicates; data and last held stable during ready=0.
3. Clamping and error: 2 words stored, i_data_num=5 -> 8 symbols sent. Then i_clear, start -> o_err pulses once, o_sym_valid stays 0.
4. Overflow: DEPTH=16, write 17 words -> o_words=16, o_overflow=1; the 17th word is never transmitted. i_clear -> o_overflow=0, o_words=0.
5. Repeat: i_repeat=1, 2 words, ready=1 -> 01..08,01..08,... with no gap. Pulse i_tx_stop mid-frame -> the current frame completes through 08 (last=1), then IDLE.
6. Reset mid-frame and preamble: with DIGITAL_TX_PREAMBLE_EN, start -> 55,55,55,55,01..08. Drop rst_n after the third data symbol -> all outputs 0 on the next cycle, no further valid.

Source files
------------

// File: rtl/digital_tx_pkg.sv
// Shared types and helpers for the digital TX symbol streamer.
// Optional build macro: DIGITAL_TX_PREAMBLE_EN (enables the preamble state).
package digital_tx_pkg;

    // Streamer FSM states; ST_PRE is only reachable when the preamble is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_SEND = 2'd2
    } tx_state_t;

    // Default preamble symbol (alternating bit pattern).
    localparam logic [7:0] DEFAULT_PRE_SYM = 8'h55;

    // Bits needed to index 'value' items; never returns less than 1 so that
    // degenerate sizes (e.g. one symbol per word) still give a legal vector.
    function automatic int clog2_min1(input int value);
        int width;
        width = 32'sd1;
        while ((32'sd1 <<< width) < value) begin
            width = width + 32'sd1;
        end
        return width;
    endfunction

    // Symbols per host word.
    function automatic int spw_of(input int data_width, input int sym_width);
        return data_width / sym_width;
    endfunction

endpackage

// File: rtl/digital_tx_buf.sv
// Word buffer for the digital TX streamer: DEPTH x DATA_WIDTH storage with a
// write pointer (which doubles as the stored-word count), a sticky overflow
// flag and a combinational read port that forwards a same-cycle write.
// Optional build macro: DIGITAL_TX_PREAMBLE_EN (not used in this file).
module digital_tx_buf
    import digital_tx_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int AW         = clog2_min1(DEPTH),
    localparam int CNT_W      = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic                  clr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0]      words,
    output logic [CNT_W-1:0]      words_next,
    output logic                  overflow
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0]      ptr_r;
    logic [CNT_W-1:0]      ptr_next_s;
    logic                  ovf_r;
    logic                  full_s;
    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    assign full_s  = (ptr_r == CNT_W'(DEPTH));
    // Clear wins over a write; a write into a full buffer is dropped.
    assign wr_en_s = wr_req & ~clr_req & ~full_s;

    // Next write pointer, also exported so a same-cycle start sees the new count.
    always_comb begin
        ptr_next_s = ptr_r;
        if (clr_req) begin
            ptr_next_s = '0;
        end else if (wr_en_s) begin
            ptr_next_s = ptr_r + CNT_W'(1);
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Write pointer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            ptr_r <= ptr_next_s;
            if (clr_req) begin
                ovf_r <= 1'b0;
            end else if (wr_req && full_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Storage array; contents survive frames and clears, only the pointer moves.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Read port with write forwarding so a start issued together with the
    // first write can present that word on the very next cycle.
    always_comb begin
        rd_data_s = mem_r[rd_addr];
        if (wr_en_s && (ptr_r[AW-1:0] == rd_addr)) begin
            rd_data_s = wr_data;
        end else begin
            rd_data_s = mem_r[rd_addr];
        end
    end

    assign rd_data    = rd_data_s;
    assign words      = ptr_r;
    assign words_next = ptr_next_s;
    assign overflow   = ovf_r;

endmodule

// File: rtl/digital_tx_stream.sv
// Digital TX symbol streamer: buffers host words and serialises them
// LSB-symbol-first on a ready/valid stream with frame-last marking,
// clamped frame length, start-error pulse and continuous repeat.
// Optional build macro: DIGITAL_TX_PREAMBLE_EN -- when defined, each started
// frame is preceded by PRE_LEN copies of PRE_SYM (not resent on repeat).
module digital_tx_stream
    import digital_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SYM_WIDTH  = 8,
    parameter int DEPTH      = 16,
    parameter int NUM_WIDTH  = 32
`ifdef DIGITAL_TX_PREAMBLE_EN
    ,
    parameter int                   PRE_LEN = 4,
    parameter logic [SYM_WIDTH-1:0] PRE_SYM = SYM_WIDTH'(DEFAULT_PRE_SYM)
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_clear,
    input  logic [NUM_WIDTH-1:0]          i_data_num,
    input  logic                          i_tx_start,
    input  logic                          i_repeat,
    input  logic                          i_tx_stop,
    output logic [SYM_WIDTH-1:0]          o_sym_data,
    output logic                          o_sym_valid,
    input  logic                          i_sym_ready,
    output logic                          o_sym_last,
    output logic                          o_busy,
    output logic [clog2_min1(DEPTH):0]    o_words,
    output logic                          o_overflow,
    output logic                          o_err
);

    localparam int SPW    = spw_of(DATA_WIDTH, SYM_WIDTH);
    localparam int SYM_CW = clog2_min1(SPW);
    localparam int AW     = clog2_min1(DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int CMP_W  = (NUM_WIDTH > CNT_W) ? NUM_WIDTH : CNT_W;
    localparam logic [SYM_CW-1:0] SYM_LAST = SYM_CW'(SPW - 1);
`ifdef DIGITAL_TX_PREAMBLE_EN
    localparam int PRE_CW = clog2_min1(PRE_LEN);
    localparam logic [PRE_CW-1:0] PRE_LAST = PRE_CW'(PRE_LEN - 1);
`endif

    // Frame state: the index registers always point at the symbol currently
    // presented on the output registers.
    tx_state_t           state_r, state_s;
    logic [AW-1:0]       word_r, word_s;
    logic [SYM_CW-1:0]   sym_r, sym_s;
    logic [CNT_W-1:0]    n_r, n_s;
    logic                stop_r, stop_s;
`ifdef DIGITAL_TX_PREAMBLE_EN
    logic [PRE_CW-1:0]   pre_cnt_r, pre_cnt_s;
`endif

    // Registered outputs and their next values.
    logic [SYM_WIDTH-1:0] data_r, data_s;
    logic                 valid_r, valid_s;
    logic                 last_r, last_s;
    logic                 busy_r, busy_s;
    logic                 err_r, err_s;

    logic                 idle_s;
    logic                 xfer_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [SPW-1:0][SYM_WIDTH-1:0] syms_s;
    logic [CNT_W-1:0]     words_s;
    logic [CNT_W-1:0]     words_next_s;
    logic                 overflow_s;
    logic [CMP_W-1:0]     num_ext_s;
    logic [CMP_W-1:0]     cnt_ext_s;
    logic [CNT_W-1:0]     n_calc_s;

    assign idle_s = (state_r == ST_IDLE);
    assign xfer_s = valid_r & i_sym_ready;
    assign syms_s = rd_data_s;

    digital_tx_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_req     (i_valid & idle_s),
        .clr_req    (i_clear & idle_s),
        .wr_data    (i_data),
        .rd_addr    (word_s),
        .rd_data    (rd_data_s),
        .words      (words_s),
        .words_next (words_next_s),
        .overflow   (overflow_s)
    );

    // Frame length clamped to the count after any same-cycle write or clear.
    assign num_ext_s = CMP_W'(i_data_num);
    assign cnt_ext_s = CMP_W'(words_next_s);
    assign n_calc_s  = (num_ext_s < cnt_ext_s) ? CNT_W'(num_ext_s) : words_next_s;

    // Next-state logic: start/reject, preamble count, index advance, repeat/stop.
    always_comb begin
        state_s = state_r;
        word_s  = word_r;
        sym_s   = sym_r;
        n_s     = n_r;
        stop_s  = stop_r;
        err_s   = 1'b0;
`ifdef DIGITAL_TX_PREAMBLE_EN
        pre_cnt_s = pre_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                stop_s = 1'b0;
                if (i_tx_start) begin
                    n_s = n_calc_s;
                    if (n_calc_s == '0) begin
                        err_s = 1'b1;
                    end else begin
                        word_s = '0;
                        sym_s  = '0;
`ifdef DIGITAL_TX_PREAMBLE_EN
                        state_s   = ST_PRE;
                        pre_cnt_s = '0;
`else
                        state_s = ST_SEND;
`endif
                    end
                end else begin
                    n_s = n_r;
                end
            end
            ST_PRE: begin
`ifdef DIGITAL_TX_PREAMBLE_EN
                if (xfer_s) begin
                    if (pre_cnt_r == PRE_LAST) begin
                        state_s   = ST_SEND;
                        pre_cnt_s = '0;
                    end else begin
                        pre_cnt_s = pre_cnt_r + PRE_CW'(1);
                    end
                end else begin
                    pre_cnt_s = pre_cnt_r;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            ST_SEND: begin
                stop_s = stop_r | i_tx_stop;
                if (xfer_s) begin
                    if (last_r) begin
                        if (i_repeat && !stop_s) begin
                            word_s = '0;
                            sym_s  = '0;
                        end else begin
                            state_s = ST_IDLE;
                            stop_s  = 1'b0;
                            word_s  = '0;
                            sym_s   = '0;
                        end
                    end else if (sym_r == SYM_LAST) begin
                        sym_s  = '0;
                        word_s = word_r + AW'(1);
                    end else begin
                        sym_s = sym_r + SYM_CW'(1);
                    end
                end else begin
                    stop_s = stop_r | i_tx_stop;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the symbol the next state will present.
    always_comb begin
        valid_s = (state_s != ST_IDLE);
        busy_s  = (state_s != ST_IDLE);
        data_s  = '0;
        last_s  = 1'b0;
        if (state_s == ST_SEND) begin
            data_s = syms_s[sym_s];
            last_s = ({1'b0, word_s} == (n_s - CNT_W'(1))) && (sym_s == SYM_LAST);
        end
`ifdef DIGITAL_TX_PREAMBLE_EN
        else if (state_s == ST_PRE) begin
            data_s = PRE_SYM;
            last_s = 1'b0;
        end
`endif
        else begin
            data_s = '0;
            last_s = 1'b0;
        end
    end

    // State and output registers; reset aborts any frame on the spot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            word_r  <= '0;
            sym_r   <= '0;
            n_r     <= '0;
            stop_r  <= 1'b0;
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            word_r  <= word_s;
            sym_r   <= sym_s;
            n_r     <= n_s;
            stop_r  <= stop_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            busy_r  <= busy_s;
            err_r   <= err_s;
        end
    end

`ifdef DIGITAL_TX_PREAMBLE_EN
    // Preamble symbol counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_s;
        end
    end
`endif

    assign o_sym_data  = data_r;
    assign o_sym_valid = valid_r;
    assign o_sym_last  = last_r;
    assign o_busy      = busy_r;
    assign o_err       = err_r;
    assign o_words     = words_s;
    assign o_overflow  = overflow_s;

endmodule

// File: tb/tb_digital_tx_stream.sv
// Self-checking bench for digital_tx_stream. A word-level model (stored words,
// count, overflow) expands each started frame into an expected symbol queue;
// one monitor compares every presented symbol against the queue head.
module tb_digital_tx_stream;

    localparam int DW    = 32;
    localparam int SW    = 8;
    localparam int DEPTH = 16;
    localparam int NW    = 32;
    localparam int SPW   = DW / SW;
`ifdef DIGITAL_TX_PREAMBLE_EN
    localparam int PRE_N = 4;
`else
    localparam int PRE_N = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          i_clear;
    logic [NW-1:0] i_data_num;
    logic          i_tx_start;
    logic          i_repeat;
    logic          i_tx_stop;
    logic [SW-1:0] o_sym_data;
    logic          o_sym_valid;
    logic          i_sym_ready;
    logic          o_sym_last;
    logic          o_busy;
    logic [4:0]    o_words;
    logic          o_overflow;
    logic          o_err;

    digital_tx_stream #(
        .DATA_WIDTH (DW),
        .SYM_WIDTH  (SW),
        .DEPTH      (DEPTH),
        .NUM_WIDTH  (NW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_clear     (i_clear),
        .i_data_num  (i_data_num),
        .i_tx_start  (i_tx_start),
        .i_repeat    (i_repeat),
        .i_tx_stop   (i_tx_stop),
        .o_sym_data  (o_sym_data),
        .o_sym_valid (o_sym_valid),
        .i_sym_ready (i_sym_ready),
        .o_sym_last  (o_sym_last),
        .o_busy      (o_busy),
        .o_words     (o_words),
        .o_overflow  (o_overflow),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          last;
        logic [SW-1:0] data;
    } sym_t;

    sym_t          exp_q[$];
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt = 0;
    logic          m_ovf = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: host write while idle.
    task automatic wr(input logic [DW-1:0] w);
        i_valid = 1'b1;
        i_data  = w;
        tick();
        i_valid = 1'b0;
        if (m_cnt == DEPTH) m_ovf = 1'b1;
        else begin
            m_mem[m_cnt] = w;
            m_cnt++;
        end
    endtask

    task automatic clr();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Model: expected symbols of one started frame of n words.
    task automatic push_frame(input int n, input bit with_pre);
        sym_t e;
        if (with_pre) begin
            for (int i = 0; i < PRE_N; i++) begin
                e.last = 1'b0;
                e.data = 8'h55;
                exp_q.push_back(e);
            end
        end
        for (int w = 0; w < n; w++) begin
            for (int s = 0; s < SPW; s++) begin
                e.last = (w == n - 1) && (s == SPW - 1);
                e.data = SW'(m_mem[w] >> (SW * s));
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start(input int num);
        i_data_num = NW'(num);
        i_tx_start = 1'b1;
        tick();
        i_tx_start = 1'b0;
    endtask

    // Runs until the expected queue drains. mode 1 toggles ready 1,0,0,1;
    // mode 2 also pulses stop at stop_at and injects a busy write+start at cycle 3.
    task automatic run_frame(input int mode, input int stop_at, output int cycles);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 400) begin
            i_sym_ready = (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            i_tx_stop   = (mode == 2) && (c == stop_at);
            i_valid     = (mode == 2) && (c == 3);
            i_tx_start  = (mode == 2) && (c == 3);
            i_data      = 32'hdeadbeef;
            tick();
            c++;
            chk("err_in_frame", {31'd0, o_err}, 32'd0);
        end
        i_sym_ready = 1'b1;
        i_tx_stop   = 1'b0;
        i_valid     = 1'b0;
        i_tx_start  = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d symbols left expected 0", exp_q.size());
            exp_q.delete();
        end
        cycles = c;
    endtask

    // Monitor: every presented symbol must match the queue head; valid may only
    // fall after a transfer.
    logic prev_valid = 1'b0;
    logic prev_xfer  = 1'b0;
    always @(negedge clk) begin
        if (o_sym_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %0h expected no symbol at %0t", o_sym_data, $time);
            end else begin
                chk("sym_data", {24'd0, o_sym_data}, {24'd0, exp_q[0].data});
                chk("sym_last", {31'd0, o_sym_last}, {31'd0, exp_q[0].last});
                if (i_sym_ready === 1'b1) void'(exp_q.pop_front());
            end
        end else if (prev_valid && !prev_xfer && rst_n) begin
            chk("valid_hold", {31'd0, o_sym_valid}, 32'd1);
        end
        prev_valid = (o_sym_valid === 1'b1);
        prev_xfer  = (o_sym_valid === 1'b1) && (i_sym_ready === 1'b1);
    end

    initial begin
        int cyc;
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_clear = 1'b0; i_data_num = '0;
        i_tx_start = 1'b0; i_repeat = 1'b0; i_tx_stop = 1'b0; i_sym_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", {31'd0, o_sym_valid}, 32'd0);
        chk("rst_data", {24'd0, o_sym_data}, 32'd0);
        chk("rst_last", {31'd0, o_sym_last}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_words", {27'd0, o_words}, 32'd0);
        chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic frame
        wr(32'h04030201);
        wr(32'h08070605);
        chk("t1_words", {27'd0, o_words}, 32'd2);
        push_frame(2, 1'b1);
        start(2);
        chk("t1_first_valid", {31'd0, o_sym_valid}, 32'd1);
        chk("t1_first_data", {24'd0, o_sym_data}, (PRE_N != 0) ? 32'h55 : 32'h01);
        run_frame(0, -1, cyc);
        chk("t1_cycles", cyc, PRE_N + 8);
        chk("t1_busy_fall", {31'd0, o_busy}, 32'd0);
        chk("t1_valid_fall", {31'd0, o_sym_valid}, 32'd0);

        // 2: backpressure, same stored frame
        push_frame(2, 1'b1);
        start(2);
        run_frame(1, -1, cyc);
        tick();
        chk("t2_busy", {31'd0, o_busy}, 32'd0);

        // 3: clamping, then rejected start on empty buffer
        clr();
        chk("t3_words_clr", {27'd0, o_words}, 32'd0);
        wr(32'h0d0c0b0a);
        wr(32'h11100f0e);
        push_frame(2, 1'b1);
        start(5);
        run_frame(0, -1, cyc);
        chk("t3_clamp_cycles", cyc, PRE_N + 8);
        clr();
        start(5);
        chk("t3_err_pulse", {31'd0, o_err}, 32'd1);
        chk("t3_err_valid", {31'd0, o_sym_valid}, 32'd0);
        tick();
        chk("t3_err_once", {31'd0, o_err}, 32'd0);
        chk("t3_err_busy", {31'd0, o_busy}, 32'd0);

        // 4: overflow; 17th word dropped and never sent
        for (int i = 0; i < 17; i++) wr(32'h03020100 + 32'h04040404 * i);
        chk("t4_words", {27'd0, o_words}, 32'd16);
        chk("t4_ovf", {31'd0, o_overflow}, 32'd1);
        chk("t4_model_cnt", {27'd0, o_words}, m_cnt);
        push_frame(16, 1'b1);
        start(17);
        run_frame(0, -1, cyc);
        chk("t4_ovf_sticky", {31'd0, o_overflow}, 32'd1);
        clr();
        chk("t4_clr_words", {27'd0, o_words}, 32'd0);
        chk("t4_clr_ovf", {31'd0, o_overflow}, 32'd0);
        // write and start in the same cycle: count includes the new word
        m_mem[0] = 32'hc3c2c1c0;
        m_cnt = 1;
        push_frame(1, 1'b1);
        i_valid = 1'b1;
        i_data = 32'hc3c2c1c0;
        start(3);
        i_valid = 1'b0;
        run_frame(0, -1, cyc);
        chk("t4_wr_start_words", {27'd0, o_words}, 32'd1);

        // 5: repeat with stop mid third frame; busy write/start ignored
        clr();
        wr(32'h04030201);
        wr(32'h08070605);
        i_repeat = 1'b1;
        push_frame(2, 1'b1);
        push_frame(2, 1'b0);
        push_frame(2, 1'b0);
        start(2);
        run_frame(2, PRE_N + 18, cyc);
        chk("t5_cycles", cyc, PRE_N + 24);
        chk("t5_busy", {31'd0, o_busy}, 32'd0);
        chk("t5_words", {27'd0, o_words}, 32'd2);
        i_repeat = 1'b0;
        tick(); tick();
        chk("t5_idle_valid", {31'd0, o_sym_valid}, 32'd0);

        // 6: restart from persisted buffer, reset after third data symbol
        push_frame(2, 1'b1);
        start(2);
        for (int k = 0; k < PRE_N + 3; k++) tick();
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        chk("t6_valid", {31'd0, o_sym_valid}, 32'd0);
        chk("t6_data", {24'd0, o_sym_data}, 32'd0);
        chk("t6_last", {31'd0, o_sym_last}, 32'd0);
        chk("t6_busy", {31'd0, o_busy}, 32'd0);
        chk("t6_words", {27'd0, o_words}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("t6_no_valid", {31'd0, o_sym_valid}, 32'd0);
        chk("t6_words_after", {27'd0, o_words}, m_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
